// File: rtl/mdu_sequencer.sv
// Iterative RV32M unsigned multiply/divide sequencer. It shares the EX-stage ALU instead of using its own adder.
// Multiply uses shift-add. Divide uses a restoring algorithm with one iteration per cycle.
module mdu_sequencer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] rs1,
    input  logic [N-1:0] rs2,
    input  logic         flush,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [N-1:0] alu_result,
    input  logic         alu_carry,
    output logic         alu_own,
    output logic         busy,
    output logic         stall,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;

    typedef enum logic [1:0] {IDLE, MUL_STEP, DIV_STEP, FINISH} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [N-1:0]   acc_q, acc_d;   // P for multiply, R for divide
    logic [N-1:0]   quo_q, quo_d;   // Q: multiplier/product-low or dividend/quotient
    logic [N-1:0]   opd_q, opd_d;   // M or D
    logic [N-1:0]   res_q, res_d;

    logic           last_step;
    logic           rmsb;
    logic           ok;
    logic [N-1:0]   rs_shift;
    logic [N-1:0]   fin_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            opd_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            opd_q   <= opd_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        opd_d     = opd_q;
        res_d     = res_q;
        alu_a     = '0;
        alu_b     = '0;
        alu_sel   = SEL_ADD;
        alu_own   = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        last_step = (cnt_q == CW'(N - 1));
        // The remainder's top bit acts as a 33rd bit, so the shifted remainder cannot overflow.
        rmsb      = acc_q[N-1];
        rs_shift  = {acc_q[N-2:0], quo_q[N-1]};
        ok        = rmsb | alu_carry;

        case (op_q)
            2'b00:   fin_val = quo_q;
            2'b01:   fin_val = acc_q;
            2'b10:   fin_val = (opd_q == '0) ? '1 : quo_q;
            default: fin_val = (opd_q == '0) ? quo_q : acc_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    stall = 1'b1;
                    op_d  = op;
                    opd_d = rs2;
                    quo_d = rs1;
                    acc_d = '0;
                    cnt_d = '0;
                    if (!op[1])          state_d = MUL_STEP;
                    else if (rs2 == '0)  state_d = FINISH;
                    else                 state_d = DIV_STEP;
                end
            end
            MUL_STEP: begin
                alu_own = 1'b1;
                stall   = 1'b1;
                alu_a   = acc_q;
                alu_b   = opd_q;
                if (quo_q[0]) {acc_d, quo_d} = {alu_carry, alu_result, quo_q[N-1:1]};
                else          {acc_d, quo_d} = {1'b0, acc_q, quo_q[N-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (last_step) state_d = FINISH;
            end
            DIV_STEP: begin
                alu_own = 1'b1;
                stall   = 1'b1;
                alu_a   = rs_shift;
                alu_b   = opd_q;
                alu_sel = SEL_SUB;
                acc_d   = ok ? alu_result : rs_shift;
                quo_d   = {quo_q[N-2:0], ok};
                cnt_d   = cnt_q + 1'b1;
                if (last_step) state_d = FINISH;
            end
            default: begin
                done    = 1'b1;
                res_d   = fin_val;
                state_d = IDLE;
            end
        endcase

        if (flush) state_d = IDLE;
    end

    assign busy   = (state_q != IDLE);
    assign result = (state_q == FINISH) ? fin_val : res_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer. A behavioural ALU and a reference model are checked on every cycle.
// The stimulus combines directed cases and randomized operations.
module tb_mdu_sequencer;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] rs1, rs2;
    logic         flush;
    logic [N-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_sel;
    logic         alu_carry;
    logic         alu_own, busy, stall, done;
    logic [N-1:0] result;

    mdu_sequencer #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .flush(flush), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_own(alu_own),
        .busy(busy), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Shared EX ALU: add, or subtract as a + ~b + 1 so that carry=1 means no borrow.
    always_comb begin
        if (alu_sel == 4'b0110) {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        else                    {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: age = cycles since accept (-1 when idle), lat = cycle of done.
    int           m_age = -1;
    int           m_lat = 0;
    logic         m_div = 1'b0;
    logic [N-1:0] m_exp = '0;
    logic [N-1:0] m_res_last = '0;

    logic         got_done;
    logic [N-1:0] got_res;
    int           n_done = 0;

    function automatic logic [N-1:0] ref_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        case (o)
            2'd0:    return p[N-1:0];
            2'd1:    return p[2*N-1:N];
            2'd2:    return (b == 0) ? {N{1'b1}} : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model across the edge.
    task automatic cycle(input logic s, input logic [1:0] o, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic f);
        logic e_own, e_done, e_stall;
        start = s; op = o; rs1 = a; rs2 = b; flush = f;
        #2;
        if (m_age >= 1) begin
            e_done  = (m_age == m_lat);
            e_own   = (m_age < m_lat);
            e_stall = e_own;
        end else begin
            e_done  = 1'b0;
            e_own   = 1'b0;
            e_stall = s & ~f;
        end
        chk("busy", busy, m_age >= 1);
        chk("done", done, e_done);
        chk("alu_own", alu_own, e_own);
        chk("stall", stall, e_stall);
        if (e_own) begin
            chk("alu_sel", alu_sel, m_div ? 4'b0110 : 4'b0010);
        end else begin
            chk("alu_a_idle", alu_a, 0);
            chk("alu_b_idle", alu_b, 0);
            chk("alu_sel_idle", alu_sel, 4'b0010);
        end
        if (e_done) begin
            chk("result", result, m_exp);
            m_res_last = m_exp;
        end
        if (m_age < 0) chk("result_hold", result, m_res_last);
        got_done = done;
        got_res  = result;
        if (done) n_done++;

        if (f) m_age = -1;
        else if (m_age < 0) begin
            if (s) begin
                m_age = 1;
                m_lat = (o[1] && b == 0) ? 1 : N + 1;
                m_div = o[1];
                m_exp = ref_op(o, a, b);
            end
        end else if (m_age == m_lat) m_age = -1;
        else m_age++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp_res, input int exp_lat, input string name);
        int  k;
        bit  seen;
        seen = 1'b0;
        k    = 0;
        cycle(1'b1, o, a, b, 1'b0);
        for (int i = 1; i <= 40 && !seen; i++) begin
            cycle(1'b0, 2'd0, '0, '0, 1'b0);
            if (got_done) begin
                seen = 1'b1;
                k    = i;
            end
        end
        chk({name, "_finished"}, seen, 1'b1);
        if (seen) begin
            chk({name, "_value"}, got_res, exp_res);
            chk({name, "_latency"}, k, exp_lat);
        end
    endtask

    initial begin
        int dn;
        logic [N-1:0] a, b;
        rst_n = 1'b0; start = 1'b0; op = '0; rs1 = '0; rs2 = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_own", alu_own, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_sel", alu_sel, 4'b0010);
        chk("rst_result", result, 0);
        rst_n = 1'b1;

        run_op(2'd0, 32'd7, 32'd6, 32'h0000002A, 33, "mul_7x6");
        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max");
        run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, "mul_max");
        run_op(2'd2, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
        run_op(2'd3, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
        run_op(2'd2, 32'hFFFFFFFF, 32'h80000001, 32'd1, 33, "divu_rmsb");
        run_op(2'd3, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33, "remu_rmsb");
        run_op(2'd2, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu_by0");
        run_op(2'd3, 32'd5, 32'd0, 32'd5, 1, "remu_by0");

        // Start stays high through FINISH and must not retrigger.
        dn = n_done;
        for (int i = 0; i < 34; i++) cycle(1'b1, 2'd0, 32'd3, 32'd5, 1'b0);
        cycle(1'b0, 2'd0, '0, '0, 1'b0);
        chk("held_start_one_done", n_done - dn, 1);

        run_op(2'd0, 32'd12, 32'd11, 32'd132, 33, "back2back_a");
        run_op(2'd3, 32'd1000, 32'd33, 32'd10, 33, "back2back_b");

        // Flush a divide at cycle 10.
        dn = n_done;
        cycle(1'b1, 2'd2, 32'd999, 32'd4, 1'b0);
        for (int i = 1; i < 10; i++) cycle(1'b0, 2'd0, '0, '0, 1'b0);
        cycle(1'b0, 2'd0, '0, '0, 1'b1);
        chk("flush_idle", busy, 0);
        chk("flush_result_kept", result, 32'd10);
        for (int i = 0; i < 30; i++) cycle(1'b0, 2'd0, '0, '0, 1'b0);
        chk("flush_no_done", n_done - dn, 0);

        // Randomized operations, including occasional flushes and zero divisors.
        for (int i = 0; i < 3000; i++) begin
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = $urandom_range(1, 9);
                2: begin a = 32'hFFFFFFFF; b = 32'h80000000 | $urandom_range(0, 3); end
                3: a = $urandom_range(0, 50);
                default: ;
            endcase
            cycle($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), a, b,
                  $urandom_range(0, 59) == 0);
        end
        for (int i = 0; i < 40; i++) cycle(1'b0, 2'd0, '0, '0, 1'b0);

        // Asynchronous reset during a divide.
        cycle(1'b1, 2'd2, 32'd1000, 32'd3, 1'b0);
        for (int i = 1; i < 5; i++) cycle(1'b0, 2'd0, '0, '0, 1'b0);
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_own", alu_own, 0);
        chk("async_rst_result", result, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_age = -1;
        m_res_last = '0;
        run_op(2'd3, 32'd17, 32'd5, 32'd2, 33, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
